// File: rtl/display_pkg.sv
// Shared types and width helpers for the seven-segment digit-scan sequencer.
// Pure declarations; no logic, no latency, no flow control.
package display_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } scan_state_t;

   localparam int BRIGHT_W = 4;

   // Index/counter width that never collapses to zero bits.
   function automatic int sel_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/display_scan_sequencer_if.sv
// Scan control/status bundle between the display top and the digit-scan sequencer.
// Brightness input exists only when DISPLAY_SCAN_BRIGHTNESS_EN is defined; levels only, no handshake.
interface display_scan_sequencer_if #(parameter int NUM_DIGITS = 4);
   import display_pkg::*;

   localparam int SEL_W = sel_w(NUM_DIGITS);

   logic                  en;
   logic [NUM_DIGITS-1:0] digit_mask;
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
   logic [BRIGHT_W-1:0]   brightness;
`endif
   logic [SEL_W-1:0]      sync_count;
   logic [NUM_DIGITS-1:0] digit_onehot;
   logic                  blank;
   logic                  frame_start;

   modport master (
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
      input  brightness,
`endif
      input  en, digit_mask,
      output sync_count, digit_onehot, blank, frame_start
   );

   modport slave (
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
      output brightness,
`endif
      output en, digit_mask,
      input  sync_count, digit_onehot, blank, frame_start
   );

endinterface

// File: rtl/display_scan_sequencer_scan_next_digit.sv
// Wrap-around priority search: next set mask bit above cur, else lowest set bit (wrap=1).
// Purely combinational, zero latency; mask==0 yields index 0 with wrap set.
module scan_next_digit #(
   parameter int NUM_DIGITS = 4,
   parameter int SEL_W      = 2
) (
   input  logic [SEL_W-1:0]      cur,
   input  logic [NUM_DIGITS-1:0] mask,
   output logic [SEL_W-1:0]      nxt,
   output logic                  wrap
);

   logic             above_hit;
   logic [SEL_W-1:0] above_idx;
   logic [SEL_W-1:0] low_idx;

   // Descending walk: the last hit written is the lowest qualifying index.
   always_comb begin
      above_hit = 1'b0;
      above_idx = '0;
      low_idx   = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (mask[i]) begin
            low_idx = SEL_W'(i);
            if (SEL_W'(i) > cur) begin
               above_hit = 1'b1;
               above_idx = SEL_W'(i);
            end
         end
      end
   end

   assign nxt  = above_hit ? above_idx : low_idx;
   assign wrap = !above_hit;

endmodule

// File: rtl/display_scan_sequencer.sv
// Digit-scan sequencer: prescaled slots of blanking then show, mask skip, frame strobe (option DISPLAY_SCAN_BRIGHTNESS_EN).
// All outputs registered, one clk from inputs; en low forces idle/blank on the next edge.
module display_scan_sequencer
   import display_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int PRESCALE     = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   display_scan_sequencer_if.master scan
);

   localparam int SEL_W    = sel_w(NUM_DIGITS);
   localparam int CW       = sel_w(PRESCALE);
   localparam int SHOW_LEN = PRESCALE - BLANK_CYCLES;
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] SLOT_LAST  = CW'(PRESCALE - 1);

   scan_state_t           state_q, state_d;
   logic [SEL_W-1:0]      sync_count_q, sync_count_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [NUM_DIGITS-1:0] digit_onehot_q, digit_onehot_d;
   logic                  blank_q, blank_d;
   logic                  frame_start_q, frame_start_d;
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
   logic [CW-1:0]         on_len_q, on_len_d;
`endif

   logic                  mask_any;
   logic                  lit;
   logic [SEL_W-1:0]      nxt_idx, first_idx;
   logic                  nxt_wrap, first_wrap;

   assign mask_any = |scan.digit_mask;

   scan_next_digit #(.NUM_DIGITS(NUM_DIGITS), .SEL_W(SEL_W)) u_next (
      .cur  (sync_count_q),
      .mask (scan.digit_mask),
      .nxt  (nxt_idx),
      .wrap (nxt_wrap)
   );

   // Searching above the top index always wraps, giving the lowest enabled digit.
   scan_next_digit #(.NUM_DIGITS(NUM_DIGITS), .SEL_W(SEL_W)) u_first (
      .cur  (SEL_W'(NUM_DIGITS - 1)),
      .mask (scan.digit_mask),
      .nxt  (first_idx),
      .wrap (first_wrap)
   );

   always_comb begin
      state_d       = state_q;
      sync_count_d  = sync_count_q;
      cnt_d         = cnt_q;
      frame_start_d = 1'b0;
      lit           = 1'b0;
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
      on_len_d      = on_len_q;
`endif
      if (!scan.en) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mask_any) begin
                  state_d       = BLANK;
                  sync_count_d  = first_idx;
                  frame_start_d = first_wrap;
                  cnt_d         = '0;
               end
            end
            BLANK: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == BLANK_LAST) begin
                  state_d = SHOW;
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
                  on_len_d = CW'(((32'(scan.brightness) + 32'd1) * 32'(SHOW_LEN)) >> 4);
                  lit      = (on_len_d != '0);
`else
                  lit      = 1'b1;
`endif
               end
            end
            SHOW: begin
               if (cnt_q == SLOT_LAST) begin
                  cnt_d = '0;
                  if (!mask_any) begin
                     state_d = IDLE;
                  end else begin
                     state_d       = BLANK;
                     sync_count_d  = nxt_idx;
                     frame_start_d = nxt_wrap | (nxt_idx == first_idx);
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
                  lit = ((cnt_d - CW'(BLANK_CYCLES)) < on_len_q);
`else
                  lit = 1'b1;
`endif
               end
            end
            default: state_d = IDLE;
         endcase
      end
      digit_onehot_d = lit ? (NUM_DIGITS'(1) << sync_count_d) : '0;
      blank_d        = !lit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         sync_count_q   <= '0;
         cnt_q          <= '0;
         digit_onehot_q <= '0;
         blank_q        <= 1'b1;
         frame_start_q  <= 1'b0;
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
         on_len_q       <= '0;
`endif
      end else begin
         state_q        <= state_d;
         sync_count_q   <= sync_count_d;
         cnt_q          <= cnt_d;
         digit_onehot_q <= digit_onehot_d;
         blank_q        <= blank_d;
         frame_start_q  <= frame_start_d;
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
         on_len_q       <= on_len_d;
`endif
      end
   end

   assign scan.sync_count   = sync_count_q;
   assign scan.digit_onehot = digit_onehot_q;
   assign scan.blank        = blank_q;
   assign scan.frame_start  = frame_start_q;

endmodule

// File: tb/tb_display_scan_sequencer.sv
// Bench for display_scan_sequencer: slot-level reference model plus directed literal pins and random stimulus.
module tb_display_scan_sequencer;

   localparam int N     = 4;
   localparam int PRESC = 10;
   localparam int BLK   = 2;
   localparam int SHOWN = PRESC - BLK;

   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;
   bit   chk_en = 1'b0;

   display_scan_sequencer_if #(.NUM_DIGITS(N)) sif ();

   display_scan_sequencer #(.NUM_DIGITS(N), .PRESCALE(PRESC), .BLANK_CYCLES(BLK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .scan  (sif)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int lowest(input logic [N-1:0] m);
      for (int i = 0; i < N; i++) if (m[i]) return i;
      return 0;
   endfunction

   function automatic int next_idx(input int cur, input logic [N-1:0] m);
      for (int k = 1; k <= N; k++) if (m[(cur + k) % N]) return (cur + k) % N;
      return cur;
   endfunction

   function automatic int bright_len();
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
      return ((int'(sif.brightness) + 1) * SHOWN) >> 4;
`else
      return SHOWN;
`endif
   endfunction

   // Reference: a slot is PRESC cycles, position 0..BLK-1 dark, then lit for on_len.
   bit m_active;
   int m_idx, m_pos, m_on_len;
   bit m_frame;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 1'b0; m_idx = 0; m_pos = 0; m_frame = 1'b0; m_on_len = SHOWN;
      end else begin
         m_frame = 1'b0;
         if (!sif.en) begin
            m_active = 1'b0;
         end else if (!m_active) begin
            if (sif.digit_mask != 0) begin
               m_active = 1'b1; m_pos = 0; m_idx = lowest(sif.digit_mask); m_frame = 1'b1;
            end
         end else begin
            m_pos++;
            if (m_pos == BLK) m_on_len = bright_len();
            if (m_pos == PRESC) begin
               m_pos = 0;
               if (sif.digit_mask == 0) m_active = 1'b0;
               else begin
                  m_idx   = next_idx(m_idx, sif.digit_mask);
                  m_frame = (m_idx == lowest(sif.digit_mask));
               end
            end
         end
      end
   end

   int exp_oh;
   always @(negedge clk) begin
      if (chk_en) begin
         exp_oh = (m_active && m_pos >= BLK && (m_pos - BLK) < m_on_len) ? (1 << m_idx) : 0;
         check("model_sync_count", int'(sif.sync_count), m_idx);
         check("model_onehot", int'(sif.digit_onehot), exp_oh);
         check("model_blank", int'(sif.blank), int'(exp_oh == 0));
         check("model_frame_start", int'(sif.frame_start), int'(m_frame));
      end
   end

   int high_cnt, fr_cnt, bad_cnt;
   bit found;

   initial begin
      rst_n = 1'b0; sif.en = 1'b0; sif.digit_mask = '0;
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
      sif.brightness = 4'd15;
`endif
      step(2);
      @(negedge clk);
      check("rst_sync", int'(sif.sync_count), 0);
      check("rst_onehot", int'(sif.digit_onehot), 0);
      check("rst_blank", int'(sif.blank), 1);
      check("rst_frame", int'(sif.frame_start), 0);
      step(1); rst_n = 1'b1;
      @(negedge clk);
      check("idle_blank", int'(sif.blank), 1);
      chk_en = 1'b1;

      // Full mask scan
      step(1); sif.digit_mask = 4'b1111; sif.en = 1'b1;
      step(1);
      @(negedge clk);
      check("en_first_frame", int'(sif.frame_start), 1);
      check("en_first_sync", int'(sif.sync_count), 0);
      check("en_first_blank", int'(sif.blank), 1);
      step(2);
      @(negedge clk);
      check("first_show_onehot", int'(sif.digit_onehot), 1);
      step(8);
      @(negedge clk);
      check("slot1_sync", int'(sif.sync_count), 1);
      check("slot1_frame", int'(sif.frame_start), 0);
      check("slot1_blank", int'(sif.blank), 1);
      high_cnt = 0; fr_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         high_cnt += int'(sif.digit_onehot != 0);
         fr_cnt   += int'(sif.frame_start);
      end
      check("f1111_lit_cycles", high_cnt, 32);
      check("f1111_frames", fr_cnt, 1);

      // Drop en in the SHOW phase of digit 2
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (sif.sync_count == 2 && sif.digit_onehot != 0) found = 1'b1;
      end
      check("wait_digit2_show", int'(found), 1);
      step(1); sif.en = 1'b0;
      step(1);
      @(negedge clk);
      check("endrop_onehot", int'(sif.digit_onehot), 0);
      check("endrop_blank", int'(sif.blank), 1);
      check("endrop_sync_held", int'(sif.sync_count), 2);
      step(1); sif.en = 1'b1;
      step(1);
      @(negedge clk);
      check("reen_sync", int'(sif.sync_count), 0);
      check("reen_frame", int'(sif.frame_start), 1);

      // Sparse mask 1010
      step(1); sif.en = 1'b0; sif.digit_mask = 4'b1010;
      step(1); sif.en = 1'b1;
      step(1);
      @(negedge clk);
      check("m1010_first_sync", int'(sif.sync_count), 1);
      check("m1010_first_frame", int'(sif.frame_start), 1);
      high_cnt = 0; fr_cnt = 0; bad_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         high_cnt += int'(sif.digit_onehot != 0);
         fr_cnt   += int'(sif.frame_start);
         bad_cnt  += int'(sif.digit_onehot[0] | sif.digit_onehot[2]);
         bad_cnt  += int'(sif.sync_count != 1 && sif.sync_count != 3);
      end
      check("m1010_lit_cycles", high_cnt, 32);
      check("m1010_frames", fr_cnt, 2);
      check("m1010_skipped_lit", bad_cnt, 0);

      // Mask cleared mid-slot: slot completes, then idle
      step(1); sif.en = 1'b0; sif.digit_mask = 4'b1111;
      step(1); sif.en = 1'b1;
      step(1);
      step(4); sif.digit_mask = 4'b0000;
      step(5);
      @(negedge clk);
      check("mask0_slot_end_onehot", int'(sif.digit_onehot), 1);
      check("mask0_slot_end_blank", int'(sif.blank), 0);
      step(1);
      @(negedge clk);
      check("mask0_idle_blank", int'(sif.blank), 1);
      check("mask0_idle_onehot", int'(sif.digit_onehot), 0);
      check("mask0_idle_frame", int'(sif.frame_start), 0);
      step(20);
      @(negedge clk);
      check("mask0_still_blank", int'(sif.blank), 1);

      // Asynchronous reset in digit 1 BLANK, between edges
      sif.digit_mask = 4'b1111;
      step(1);
      step(10);
      #2 rst_n = 1'b0;
      #1;
      check("arst_sync", int'(sif.sync_count), 0);
      check("arst_onehot", int'(sif.digit_onehot), 0);
      check("arst_blank", int'(sif.blank), 1);
      check("arst_frame", int'(sif.frame_start), 0);
      sif.en = 1'b0;
      step(1); rst_n = 1'b1;
      step(2);
      @(negedge clk);
      check("post_rst_idle_blank", int'(sif.blank), 1);
      check("post_rst_idle_frame", int'(sif.frame_start), 0);

      // Random en / mask / brightness
      sif.en = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         step(1);
         if ($urandom_range(0, 99) < 2) sif.en = ~sif.en;
         if ($urandom_range(0, 99) < 1) sif.digit_mask = 4'($urandom);
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
         if ($urandom_range(0, 99) < 2) sif.brightness = 4'($urandom);
`endif
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
